rr_hold_arbiter: RTL and testbench
==================================

// Module: rr_hold_arbiter
// PURPOSE
//  Registered round-robin arbiter with grant hold and timeout. Downstream of the
//  ps2/ps4/ps8 fixed-priority select tree. Turns its combinational one-hot
//  select into a registered, fair, locked grant for multi-cycle bus ownership.
//  One requester owns the grant until it drops req, en drops, or MAX_HOLD expires.
// PARAMETERS
//  N         8    number of requesters; power of two, >=2
//  MAX_HOLD  15   max consecutive cycles one owner may hold gnt; >=1
// PORTS
//  clk       in   1                   system clock, rising edge
//  rst       in   1                   reset, asynchronous, active-high
//  en        in   1                   arbitration enable; 0 forces release
//  req       in   N                   request vector, bit i = requester i
//  gnt       out  N                   registered one-hot grant, 0 when idle
//  gnt_valid out  1                   |gnt
//  gnt_id    out  $clog2(N)           index of granted requester, 0 when idle
//  hold_cnt  out  $clog2(MAX_HOLD+1)  cycles current owner has held gnt
//  req_up    out  1                   registered: en & ~|req sampled last edge
// BEHAVIOUR
//  Reset (async assert): gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, req_up=0,
//   ptr=N-1, state=IDLE. Deassertion is taken synchronously at next clk edge.
//  Priority: MSB-highest fixed priority, rotated by ptr. Search order:
//   ptr-1, ptr-2, ... 0, N-1, ... ptr, wrapping. Implementation: masked vector
//   req & ((1<<ptr)-1) through the select tree; if zero, use unmasked req.
//  Latency: req sampled at edge k -> gnt visible after edge k (1 cycle reg).
//  FSM states IDLE, OWN:
//   IDLE: en & |req -> OWN; gnt=winner, ptr=winner, hold_cnt=1. Else stay, gnt=0.
//   OWN, en=0 -> IDLE, gnt=0 next edge, hold_cnt=0, ptr kept.
//   OWN, req[gnt_id]=1, hold_cnt<MAX_HOLD -> stay, hold_cnt+1, gnt unchanged.
//   OWN, release = req[gnt_id]=0 or hold_cnt==MAX_HOLD:
//    - other req bits set -> re-arbitrate same edge, gnt switches with no idle
//      cycle; new winner from rotated order (owner is last in order).
//    - only owner still requesting (timeout) -> regrant owner, hold_cnt=1.
//    - none -> IDLE, gnt=0.
//  gnt_id/gnt_valid always consistent with gnt (same register or derived).
//  req_up is registered every cycle, independent of state.
//  hold_cnt saturates at MAX_HOLD, never wraps; width fits MAX_HOLD.
//  Requests changing while OWN do not affect the owner until release.
//  Reset mid-grant: gnt drops immediately (async), no glitch to another id.
// STRUCTURE
//  Package arb_pkg: localparam ARB_N, ARB_MAX_HOLD; typedef enum logic
//   {ARB_IDLE, ARB_OWN} arb_state_t; typedef logic [$clog2(ARB_N)-1:0] arb_id_t.
//  Sub-module prio_sel_n: parameterized N-wide MSB-first one-hot select
//   (req, en -> gnt, req_up), two instances (masked, unmasked). Instances use
//   ps8 when N==8. Onehot-to-index encoder and FSM stay in this module.
// TESTING
//  1 Reset: rst=1 mid-grant req=8'hFF -> gnt=0, gnt_id=0, hold_cnt=0 same cycle.
//  2 Rotation: req=8'hFF held, MAX_HOLD=1 -> gnt sequence 80,40,20,...,01,80.
//  3 Hold/release: req=8'h10 for 5 cycles then 0 -> gnt=8'h10 5 cycles,
//     hold_cnt 1..5, then gnt=0, FSM IDLE.
//  4 Back-to-back: owner 2 drops req while req[5]=1 -> gnt 04 -> 20 next edge.
//  5 Timeout: req=8'h81 held, MAX_HOLD=15 -> gnt=80 for 15 cycles, then 01.
//  6 en=0 during OWN -> gnt=0 next edge; en=1 again -> search resumes at ptr-1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin hold arbiter.
package arb_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_MAX_HOLD = 15;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    typedef logic [$clog2(ARB_N)-1:0] arb_id_t;

endpackage

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_hold_arbiter_if
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD
);
    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [HW-1:0]  hold_cnt;
    logic           req_up;

    modport master (
        output en, req,
        input  gnt, gnt_valid, gnt_id, hold_cnt, req_up
    );

    modport slave (
        input  en, req,
        output gnt, gnt_valid, gnt_id, hold_cnt, req_up
    );

endinterface

// File: rtl/prio_sel_n.sv
// N-wide fixed-priority one-hot select, highest index wins; req_up flags an
// enabled but empty request vector.
module prio_sel_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic         req_up
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (en && req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

    assign req_up = en & ~(|req);

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter: the winner keeps the grant until it drops
// its request, en drops, or it has held the grant for MAX_HOLD cycles.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    rr_hold_arbiter_if.slave bus
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    arb_state_t     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           req_up_q;

    logic [N-1:0]   mask;
    logic [N-1:0]   sel_masked;
    logic [N-1:0]   sel_full;
    logic           up_masked;
    logic           up_full;
    logic [N-1:0]   winner;
    logic [IDW-1:0] winner_id;
    logic           owner_req;

    function automatic logic [IDW-1:0] onehot_to_id(input logic [N-1:0] oh);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                id = id | IDW'(i);
            end
        end
        return id;
    endfunction

    // Only requesters below ptr compete first, so the last owner ranks last.
    assign mask = (N'(1) << ptr_q) - N'(1);

    prio_sel_n #(.N(N)) u_sel_masked (
        .req    (bus.req & mask),
        .en     (bus.en),
        .gnt    (sel_masked),
        .req_up (up_masked)
    );

    prio_sel_n #(.N(N)) u_sel_full (
        .req    (bus.req),
        .en     (bus.en),
        .gnt    (sel_full),
        .req_up (up_full)
    );

    assign winner    = up_masked ? sel_full : (|sel_masked ? sel_masked : sel_full);
    assign winner_id = onehot_to_id(winner);
    assign owner_req = |(bus.req & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            ARB_IDLE: begin
                gnt_d  = '0;
                hold_d = '0;
                if (bus.en && (|bus.req)) begin
                    state_d = ARB_OWN;
                    gnt_d   = winner;
                    ptr_d   = winner_id;
                    hold_d  = HW'(1);
                end
            end
            ARB_OWN: begin
                if (!bus.en) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end else if (owner_req && (hold_q < HW'(MAX_HOLD))) begin
                    hold_d = hold_q + HW'(1);
                end else if (|bus.req) begin
                    // Release with anyone still asking: hand over on this edge.
                    gnt_d  = winner;
                    ptr_d  = winner_id;
                    hold_d = HW'(1);
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            ptr_q    <= IDW'(N - 1);
            hold_q   <= '0;
            req_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            req_up_q <= up_full;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = onehot_to_id(gnt_q);
    assign bus.hold_cnt  = hold_q;
    assign bus.req_up    = req_up_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench: dut_a uses MAX_HOLD=15, dut_b uses MAX_HOLD=1 for rotation.
module tb_rr_hold_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rr_hold_arbiter_if #(.N(8), .MAX_HOLD(15)) bus_a ();
    rr_hold_arbiter_if #(.N(8), .MAX_HOLD(1))  bus_b ();

    rr_hold_arbiter #(.N(8), .MAX_HOLD(15)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rr_hold_arbiter #(.N(8), .MAX_HOLD(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit use_b, input logic en, input logic [7:0] req);
        if (use_b) begin
            bus_b.en  = en;
            bus_b.req = req;
        end else begin
            bus_a.en  = en;
            bus_a.req = req;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic [7:0] gnt,
                          input logic [2:0] id, input logic [3:0] hold);
        checkOutput({tag, ".gnt"}, 32'(bus_a.gnt), 32'(gnt));
        checkOutput({tag, ".id"}, 32'(bus_a.gnt_id), 32'(id));
        checkOutput({tag, ".hold"}, 32'(bus_a.hold_cnt), 32'(hold));
        checkOutput({tag, ".valid"}, 32'(bus_a.gnt_valid), 32'(|gnt));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        #2;
        checkA("reset", 8'h00, 3'd0, 4'd0);
        checkOutput("reset.req_up", 32'(bus_a.req_up), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Hold then release: requester 4 alone for five edges.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h10);
            tick();
            checkA("hold", 8'h10, 3'd4, 4'(i));
        end
        checkOutput("hold.req_up", 32'(bus_a.req_up), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        checkA("release", 8'h00, 3'd0, 4'd0);
        checkOutput("release.req_up", 32'(bus_a.req_up), 32'd1);

        // Back-to-back handover 2 -> 5 with no idle cycle.
        applyStimulus(1'b0, 1'b1, 8'h04);
        tick();
        checkA("b2b.own2", 8'h04, 3'd2, 4'd1);
        applyStimulus(1'b0, 1'b1, 8'h24);
        tick();
        checkA("b2b.keep2", 8'h04, 3'd2, 4'd2);
        applyStimulus(1'b0, 1'b1, 8'h20);
        tick();
        checkA("b2b.own5", 8'h20, 3'd5, 4'd1);
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        checkA("b2b.idle", 8'h00, 3'd0, 4'd0);

        // Park ptr at 0 so requester 7 wins next.
        applyStimulus(1'b0, 1'b1, 8'h01);
        tick();
        checkA("park", 8'h01, 3'd0, 4'd1);
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();

        // Timeout: 7 holds for 15 edges then yields to 0.
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h81);
            tick();
            checkA("timeout.own7", 8'h80, 3'd7, 4'(i));
        end
        tick();
        checkA("timeout.own0", 8'h01, 3'd0, 4'd1);
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        checkA("timeout.idle", 8'h00, 3'd0, 4'd0);

        // en drop during ownership, then search resumes below old owner.
        applyStimulus(1'b0, 1'b1, 8'hFF);
        tick();
        checkA("en.own7", 8'h80, 3'd7, 4'd1);
        tick();
        checkA("en.keep7", 8'h80, 3'd7, 4'd2);
        applyStimulus(1'b0, 1'b0, 8'hFF);
        tick();
        checkA("en.off", 8'h00, 3'd0, 4'd0);
        checkOutput("en.off.req_up", 32'(bus_a.req_up), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        tick();
        checkA("en.resume", 8'h40, 3'd6, 4'd1);

        // Asynchronous reset in the middle of a grant.
        #3;
        rst = 1'b1;
        #1;
        checkA("rst.async", 8'h00, 3'd0, 4'd0);
        tick();
        checkA("rst.held", 8'h00, 3'd0, 4'd0);
        rst = 1'b0;
        tick();
        checkA("rst.after", 8'h40, 3'd6, 4'd1);

        // Rotation on the MAX_HOLD=1 instance.
        applyStimulus(1'b1, 1'b1, 8'h01);
        tick();
        checkOutput("rot.first", 32'(bus_b.gnt), 32'h01);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] exp_gnt;
            exp_gnt = 8'h80 >> (i % 8);
            tick();
            checkOutput("rot.gnt", 32'(bus_b.gnt), 32'(exp_gnt));
            checkOutput("rot.hold", 32'(bus_b.hold_cnt), 32'd1);
        end
        applyStimulus(1'b1, 1'b1, 8'h80);
        tick();
        checkOutput("regrant.gnt", 32'(bus_b.gnt), 32'h80);
        checkOutput("regrant.hold", 32'(bus_b.hold_cnt), 32'd1);
        checkOutput("regrant.id", 32'(bus_b.gnt_id), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
